// File: rtl/div_stream_ctrl.sv
// Valid/ready wrapper around a free-running fixed-latency divider.
// Credits cover in-flight ops plus buffered results, so a result always has a FIFO slot.
module div_stream_ctrl #(
    parameter int AW    = 8,
    parameter int BW    = 4,
    parameter int LAT   = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_a,
    input  logic [BW-1:0] in_b,
    output logic [AW-1:0] div_a,
    output logic [BW-1:0] div_b,
    input  logic [AW-1:0] div_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_q,
    output logic          out_dz,
    output logic          busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [LAT:0]    dl_v_reg;
    logic [LAT:0]    dl_dz_reg;
    logic [CW-1:0]   inflight_reg;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [AW:0]     mem_reg [DEPTH];
    logic [AW-1:0]   cap_q;
    logic            fire;
    logic            capture;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credit decision uses registered state only; a same-cycle pop frees nothing yet.
    assign in_ready  = ({1'b0, inflight_reg} + {1'b0, count_reg}) < CREDITS;
    assign fire      = in_valid && in_ready;
    assign capture   = dl_v_reg[LAT];
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign cap_q     = dl_dz_reg[LAT] ? '1 : div_c;
    assign out_q     = mem_reg[rd_ptr_reg][AW-1:0];
    assign out_dz    = mem_reg[rd_ptr_reg][AW];
    assign busy      = (inflight_reg != '0) || (count_reg != '0);

    always_comb begin
        inflight_next = inflight_reg;
        case ({fire, capture})
            2'b10:   inflight_next = inflight_reg + CW'(1);
            2'b01:   inflight_next = inflight_reg - CW'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({capture, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_v_reg     <= '0;
            dl_dz_reg    <= '0;
            inflight_reg <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            div_a        <= '0;
            div_b        <= '0;
        end else begin
            // Stage k holds the op issued k edges ago, matching the divider pipeline.
            dl_v_reg     <= {dl_v_reg[LAT-1:0], fire};
            dl_dz_reg    <= {dl_dz_reg[LAT-1:0], fire && (in_b == '0)};
            inflight_reg <= inflight_next;
            count_reg    <= count_next;
            if (fire) begin
                div_a <= in_a;
                div_b <= in_b;
            end
            if (capture) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // Storage needs no reset: entries are only read when count_reg covers them.
    always_ff @(posedge clk) begin
        if (capture && (count_reg != FULL_CNT || pop)) begin
            mem_reg[wr_ptr_reg] <= {dl_dz_reg[LAT], cap_q};
        end
    end

endmodule

// File: tb/tb_div_stream_ctrl.sv
// Scoreboard bench for div_stream_ctrl with a behavioural fixed-latency divider.
module tb_div_stream_ctrl;

    localparam int AW    = 8;
    localparam int BW    = 4;
    localparam int LAT   = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic [AW-1:0] div_a;
    logic [BW-1:0] div_b;
    logic [AW-1:0] div_c;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_q;
    logic          out_dz;
    logic          busy;

    logic [AW-1:0] exp_q = '0;
    logic          exp_dz = 1'b0;
    logic [AW:0]   sb_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] pipe [LAT];

    div_stream_ctrl #(.AW(AW), .BW(BW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_a(div_a), .div_b(div_b), .div_c(div_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_dz(out_dz),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Divider: garbage quotient on divide-by-zero so the override is observable.
    always @(posedge clk) begin
        pipe[0] <= (div_b == '0) ? 8'h5A : div_a / AW'(div_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign div_c = pipe[LAT-1];

    // Issue monitor: the handshake visible now completes at the next rising edge.
    always @(negedge clk) begin
        if (rst && in_valid && in_ready) begin
            sb_q.push_back({exp_dz, exp_q});
            $display("issue a=%0d b=%0d exp_q=%0d exp_dz=%0d", in_a, in_b, exp_q, exp_dz);
        end
    end

    always @(negedge clk) begin
        logic [AW:0] e;
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL result_unexpected q=%0d dz=%0d with empty scoreboard", out_q, out_dz);
            end else begin
                e = sb_q.pop_front();
                checks += 2;
                if (out_q !== e[AW-1:0]) begin
                    errors++;
                    $display("FAIL out_q got=%0d exp=%0d", out_q, e[AW-1:0]);
                end
                if (out_dz !== e[AW]) begin
                    errors++;
                    $display("FAIL out_dz got=%0d exp=%0d", out_dz, e[AW]);
                end
                $display("pop q=%0d dz=%0d exp_q=%0d exp_dz=%0d", out_q, out_dz, e[AW-1:0], e[AW]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && dut.dl_v_reg[LAT] && dut.count_reg == DEPTH) begin
            errors++;
            $display("FAIL push_when_full count=%0d exp<%0d", dut.count_reg, DEPTH);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else begin
            $display("check %s = %0d", name, got);
        end
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [AW-1:0] q, input logic dz);
        logic got;
        in_a = a; in_b = b; exp_q = q; exp_dz = dz; in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) begin
                in_valid = 1'b0;
                return;
            end
        end
        errors++;
        $display("FAIL send_timeout a=%0d b=%0d", a, b);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, LAT + 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        logic          got;
        int            issued;
        int            cyc;
        logic [AW-1:0] bp_q [8] = '{8'd1, 8'd5, 8'd7, 8'd7, 8'd8, 8'd8, 8'd8, 8'd8};

        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_div_a", int'(div_a), 0);
        check("rst_div_b", int'(div_b), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single operation and latency.
        out_ready = 1'b1;
        check("single_in_ready", int'(in_ready), 1);
        send(8'd200, 4'd7, 8'd28, 1'b0);
        check("single_div_a", int'(div_a), 200);
        wait_valid("single_latency");
        @(posedge clk);
        #1;
        check("single_busy_after_pop", int'(busy), 0);
        check("single_out_valid_after_pop", int'(out_valid), 0);

        // Divide by zero then a normal op.
        send(8'd55, 4'd0, 8'd255, 1'b1);
        wait_valid("dz_latency");
        send(8'd9, 4'd3, 8'd3, 1'b0);
        drain("dz_drain");

        // Back-pressure: fill all credits.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(AW'(10 * k + 1), BW'(k + 1), bp_q[k], 1'b0);
        end
        check("bp_in_ready_low", int'(in_ready), 0);
        in_a = 8'd99; in_b = 4'd1; exp_q = 8'd99; exp_dz = 1'b0; in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("bp_in_ready_held_low", int'(got), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain("bp_drain");
        check("bp_in_ready_restored", int'(in_ready), 1);

        // Seven results queued, then issue and pop in the same cycle.
        out_ready = 1'b0;
        send(8'd100, 4'd3, 8'd33, 1'b0);
        send(8'd77, 4'd0, 8'd255, 1'b1);
        send(8'd255, 4'd15, 8'd17, 1'b0);
        send(8'd64, 4'd8, 8'd8, 1'b0);
        send(8'd13, 4'd13, 8'd1, 1'b0);
        send(8'd0, 4'd5, 8'd0, 1'b0);
        send(8'd250, 4'd9, 8'd27, 1'b0);
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("fc_in_ready_at_7", int'(in_ready), 1);
        out_ready = 1'b1;
        send(8'd99, 4'd4, 8'd24, 1'b0);
        send(8'd200, 4'd2, 8'd100, 1'b0);
        send(8'd17, 4'd5, 8'd3, 1'b0);
        drain("fc_drain");

        // Reset while ops are in flight.
        out_ready = 1'b1;
        send(8'd40, 4'd2, 8'd20, 1'b0);
        send(8'd41, 4'd2, 8'd20, 1'b0);
        send(8'd42, 4'd2, 8'd21, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid || busy) got = 1'b1;
        end
        check("mid_rst_no_stale", int'(got), 0);
        @(posedge clk);
        #1;

        // Random stream.
        issued = 0;
        cyc = 0;
        while (issued < 500 && cyc < 20000) begin
            if (!in_valid && ($urandom_range(1) == 1)) begin
                ra = AW'($urandom_range(255));
                rb = BW'($urandom_range(15));
                in_a = ra; in_b = rb;
                exp_q  = (rb == '0) ? 8'd255 : ra / AW'(rb);
                exp_dz = (rb == '0);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(1) == 1);
            @(negedge clk);
            got = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (got) begin
                issued++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("rand_issued", issued, 500);
        drain("rand_drain");
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
